// File: rtl/posit_unpack_pkg.sv
// Shared definitions for the posit (N=32, es=2) field decoder.
// Latency: n/a (types, constants and a constant-folding helper only).
// Backpressure: n/a.
package posit_pkg;

    localparam int N  = 32;          // posit width
    localparam int ES = 2;           // exponent field width
    localparam int FW = N - 3 - ES;  // fraction field width (27)
    localparam int SW = 8;           // signed scale width
    localparam int RW = 5;           // regime run-length width (run is 1..31)

    // Decoded posit fields as delivered on the output side.
    typedef struct packed {
        logic                 sign;
        logic signed [SW-1:0] scale;
        logic [FW-1:0]        frac;
        logic                 zero;
        logic                 inf;
    } posit_fields_t;

    // NaR pattern for an n-bit posit: a 1 followed by n-1 zeros.
    function automatic logic [N-1:0] posit_nar(input int unsigned n);
        return {1'b1, {(N-1){1'b0}}} >> (N - n);
    endfunction

endpackage

// File: rtl/posit_unpack_if.sv
// Input/output handshake bundle of the posit field decoder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; master drives inputs, slave is the decoder.
interface posit_unpack_if;
    import posit_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_posit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [SW-1:0] out_scale;
    logic [FW-1:0]        out_frac;
    logic                 out_zero;
    logic                 out_inf;

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_inf
    );

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_inf
    );

endinterface

// File: rtl/posit_unpack_lzc.sv
// Leading-run counter: length and polarity of the run of identical bits from the MSB.
// Latency: combinational.
// Backpressure: none.
module posit_lzc
    import posit_pkg::*;
(
    input  logic [N-2:0]  bits_i,
    output logic [RW-1:0] run_o,
    output logic          pol_o
);

    logic done;

    // Walk from the MSB, counting bits equal to the first one until the run breaks.
    always_comb begin
        run_o = '0;
        done  = 1'b0;
        pol_o = bits_i[N-2];
        for (int i = N - 2; i >= 0; i--) begin
            if (!done) begin
                if (bits_i[i] == pol_o) begin
                    run_o = run_o + RW'(1);
                end else begin
                    done = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/posit_unpack.sv
// Posit (N=32, es=2) decoder: packed word -> sign, signed scale, left-aligned fraction, zero/NaR flags.
// Latency: 2 register stages; a word accepted on one edge is on the outputs after the next edge.
// Backpressure: full-throughput valid/ready; a stalled output holds both stages and drops in_ready.
module posit_unpack
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    posit_unpack_if.slave bus
);

    localparam logic [N-1:0] NAR = posit_nar(N);

    // Handshake: a stage may load when it is empty or the stage after it is moving.
    logic en1;
    logic en2;
    logic v1_q;
    logic v2_q;

    assign en2          = !v2_q || bus.out_ready;
    assign en1          = !v1_q || en2;
    assign bus.in_ready = en1;

    // Stage 1 next-state: magnitude, special flags and regime run.
    logic [N-1:0]  mag_d;
    logic          zero_d;
    logic          inf_d;
    logic [RW-1:0] run_d;
    logic          pol_d;

    assign mag_d  = bus.in_posit[N-1] ? -bus.in_posit : bus.in_posit;
    assign zero_d = (bus.in_posit == '0);
    assign inf_d  = (bus.in_posit == NAR);

    posit_lzc u_lzc (
        .bits_i (mag_d[N-2:0]),
        .run_o  (run_d),
        .pol_o  (pol_d)
    );

    logic          sign_q;
    logic [N-1:0]  mag_q;
    logic          zero_q;
    logic          inf_q;
    logic [RW-1:0] run_q;
    logic          pol_q;

    // Stage 1 registers: capture the word only on an actual input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            sign_q <= 1'b0;
            mag_q  <= '0;
            zero_q <= 1'b0;
            inf_q  <= 1'b0;
            run_q  <= '0;
            pol_q  <= 1'b0;
        end else if (en1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                sign_q <= bus.in_posit[N-1];
                mag_q  <= mag_d;
                zero_q <= zero_d;
                inf_q  <= inf_d;
                run_q  <= run_d;
                pol_q  <= pol_d;
            end
        end
    end

    // Stage 2 datapath: skipping the regime run plus its terminator puts the
    // exponent at the top of the shifted word, followed by the fraction.
    logic [RW:0]          shamt;
    logic [N-1:0]         shifted;
    logic signed [SW-1:0] run_s;
    logic signed [SW-1:0] k;
    logic [ES-1:0]        e;
    posit_fields_t        out_d;
    posit_fields_t        out_q;

    assign shamt   = {1'b0, run_q} + (RW + 1)'(2);
    assign shifted = mag_q << shamt;
    assign e       = shifted[N-1 -: ES];
    assign run_s   = signed'(SW'(run_q));
    assign k       = pol_q ? (run_s - SW'(1)) : (-run_s);

    // Assemble output fields; zero and NaR carry no scale or fraction.
    always_comb begin
        out_d      = '0;
        out_d.sign = sign_q;
        out_d.zero = zero_q;
        out_d.inf  = inf_q;
        if (!zero_q && !inf_q) begin
            out_d.scale = (k <<< ES) + SW'(e);
            out_d.frac  = shifted[N-1-ES -: FW];
        end
    end

    // Stage 2 registers: load when the output side can move, otherwise hold stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q  <= 1'b0;
            out_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                out_q <= out_d;
            end
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.out_sign  = out_q.sign;
    assign bus.out_scale = out_q.scale;
    assign bus.out_frac  = out_q.frac;
    assign bus.out_zero  = out_q.zero;
    assign bus.out_inf   = out_q.inf;

endmodule

// File: tb/tb_posit_unpack.sv
// Bench for posit_unpack: directed decode/latency vectors, backpressure, mid-run reset, random traffic.
// Expected fields come from a bit-walking reference decoder and a scoreboard queue.
module tb_posit_unpack;
    import posit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    posit_unpack_if bus ();

    posit_unpack dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    posit_fields_t exp_q[$];

    logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF,
                                  32'hFFFFFFFF, 32'h80000001, 32'h40000000, 32'hC0000000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic posit_fields_t mk(input logic s, input logic [SW-1:0] sc,
                                         input logic [FW-1:0] fr, input logic z, input logic i);
        posit_fields_t f;
        f.sign  = s;
        f.scale = sc;
        f.frac  = fr;
        f.zero  = z;
        f.inf   = i;
        return f;
    endfunction

    function automatic posit_fields_t seen();
        return mk(bus.out_sign, bus.out_scale, bus.out_frac, bus.out_zero, bus.out_inf);
    endfunction

    // Reference decoder: walk the regime bit by bit, then pick exponent and fraction by position.
    function automatic posit_fields_t ref_decode(input logic [31:0] p);
        posit_fields_t f;
        logic [31:0] mag;
        logic        first;
        int          r;
        int          k;
        int          pos;
        int          e;
        int          nb;
        f = '0;
        f.sign = p[31];
        if (p == 32'h0) begin
            f.zero = 1'b1;
            return f;
        end
        if (p == 32'h80000000) begin
            f.inf = 1'b1;
            return f;
        end
        mag   = p[31] ? (~p + 32'd1) : p;
        first = mag[30];
        r     = 0;
        while (r < 31 && mag[30 - r] == first) r++;
        k   = first ? r - 1 : -r;
        pos = 30 - r;                       // terminator position, -1 if the run hit bit 0
        e   = 0;
        if (pos - 1 >= 0 && mag[pos - 1]) e += 2;
        if (pos - 2 >= 0 && mag[pos - 2]) e += 1;
        nb = (pos - 2 > 0) ? pos - 2 : 0;   // fraction bits left below the exponent
        f.scale = SW'(k * 4 + e);
        f.frac  = FW'((mag & ((32'd1 << nb) - 32'd1)) << (FW - nb));
        return f;
    endfunction

    function automatic logic [31:0] gen();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 2) return specials[$urandom_range(0, 7)];
        if (sel < 5) return $urandom() >> $urandom_range(1, 31);
        return $urandom();
    endfunction

    // Scoreboard monitor: samples on the falling edge what the next rising edge will transfer.
    initial begin
        bit            stall;
        posit_fields_t held;
        posit_fields_t cur;
        posit_fields_t e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            cur = seen();
            if (reset) begin
                exp_q.delete();
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_vld", bus.out_valid, 1'b1);
                    check("hold_dat", cur, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("sb_nonempty", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_data", cur, e);
                        n_out++;
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                held  = cur;
                if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_decode(bus.in_posit));
            end
        end
    end

    // One word into an empty pipe: accepted at once, invisible after the accept edge, valid after the next.
    task automatic directed(input string tag, input logic [31:0] w, input posit_fields_t exp_f);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_posit  = w;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_acc"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_vld"}, bus.out_valid, 1'b1);
        check({tag, "_fld"}, seen(), exp_f);
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bp_w [5];
        int          idx;
        int          cyc;
        int          n0;
        logic [31:0] cur;
        bit          have;

        bp_w = '{32'h12345678, 32'hF0F0F0F0, 32'h00000003, 32'h6FFFFFFF, 32'h9ABCDEF1};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_posit  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_fields", seen(), '0);
        @(posedge clk); #1;
        reset = 1'b0;

        directed("one",   32'h40000000, mk(1'b0, 8'd0,    27'h0,       1'b0, 1'b0));
        directed("k1e1",  32'h66531748, mk(1'b0, 8'd5,    27'h04A62E90, 1'b0, 1'b0));
        directed("neg1",  32'hC0000000, mk(1'b1, 8'd0,    27'h0,       1'b0, 1'b0));
        directed("minpos",32'h00000001, mk(1'b0, 8'h88,   27'h0,       1'b0, 1'b0));
        directed("maxpos",32'h7FFFFFFF, mk(1'b0, 8'h78,   27'h0,       1'b0, 1'b0));
        directed("zero",  32'h00000000, mk(1'b0, 8'd0,    27'h0,       1'b1, 1'b0));
        directed("nar",   32'h80000000, mk(1'b1, 8'd0,    27'h0,       1'b0, 1'b1));

        // Backpressure: stream 5 words while the output is stalled, then release.
        n0  = n_out;
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 50) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.in_posit  = bp_w[idx];
            bus.out_ready = (cyc >= 6);
            @(negedge clk);
            if (cyc == 2) begin
                check("bp_in_rdy_low", bus.in_ready, 1'b0);
                check("bp_out_vld", bus.out_valid, 1'b1);
            end
            if (bus.in_ready) idx++;
            cyc++;
        end
        check("bp_sent", idx, 5);
        drain();
        check("bp_count", n_out - n0, 5);

        // Reset with both stages full.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_posit  = 32'h5A5A5A5A;
        @(posedge clk); #1;
        bus.in_posit  = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("pre_rst_full", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_mid_vld", bus.out_valid, 1'b0);
        check("rst_mid_rdy", bus.in_ready, 1'b1);
        check("rst_mid_fld", seen(), '0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        directed("post_rst", 32'h66531748, mk(1'b0, 8'd5, 27'h04A62E90, 1'b0, 1'b0));

        // Random traffic with random stalls; the upstream side holds a word until it transfers.
        have = 1'b0;
        cur  = '0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (!have && $urandom_range(0, 9) < 7) begin
                cur  = gen();
                have = 1'b1;
            end
            bus.in_valid  = have;
            bus.in_posit  = have ? cur : $urandom();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (have && bus.in_ready) have = 1'b0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
